// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit saturating
// counter per entry. Fetch lookups are purely combinational from registered
// state. Resolved branches are captured into a one-entry staging register and
// written back to the table one edge later; lookups and new captures read the
// staged entry through a bypass, so an update is visible on the very next cycle.
//
// Optional feature: define BP_STATS_EN to build the branch / mispredict
// statistics counters. Without it both stat ports are tied to zero and no
// counter flops exist.
//
// Update handshake: predict_update is a single-cycle strobe qualified by
// rdy_in; there is no back-pressure. rdy_in low freezes every register
// (table, staging, statistics) while the lookup path keeps following if_pc.
module branch_predictor #(
   parameter int IDX_BITS = 6
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        rdy_in,
   input  logic [31:0] if_pc,
   output logic        predict_result,
   output logic [31:0] npc,
   input  logic        predict_update,
   input  logic        predict_error,
   input  logic        actual_result,
   input  logic [31:0] branch_pc,
   input  logic [31:0] branch_npc1,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = 30 - IDX_BITS;

   // Table storage
   logic             tbl_valid  [ENTRIES];
   logic [TAG_W-1:0] tbl_tag    [ENTRIES];
   logic [31:0]      tbl_target [ENTRIES];
   logic [1:0]       tbl_ctr    [ENTRIES];

   // Staging register: a staged entry is always valid once written
   logic                stg_valid;
   logic [IDX_BITS-1:0] stg_idx;
   logic [TAG_W-1:0]    stg_tag;
   logic [31:0]         stg_target;
   logic [1:0]          stg_ctr;

   // Lookup side
   logic [IDX_BITS-1:0] lk_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic                lk_e_valid;
   logic [TAG_W-1:0]    lk_e_tag;
   logic [31:0]         lk_e_target;
   logic [1:0]          lk_e_ctr;
   logic                lk_hit;

   // Update side
   logic [IDX_BITS-1:0] up_idx;
   logic [TAG_W-1:0]    up_tag;
   logic                up_e_valid;
   logic [TAG_W-1:0]    up_e_tag;
   logic [31:0]         up_e_target;
   logic [1:0]          up_e_ctr;
   logic                up_hit;
   logic [31:0]         new_target;
   logic [1:0]          new_ctr;

   logic                capture;
   logic                commit;

   assign lk_idx  = if_pc[IDX_BITS+1:2];
   assign lk_tag  = if_pc[31:IDX_BITS+2];
   assign up_idx  = branch_pc[IDX_BITS+1:2];
   assign up_tag  = branch_pc[31:IDX_BITS+2];
   assign capture = rdy_in && predict_update;
   assign commit  = rdy_in && stg_valid;

   // Lookup read: table entry, overridden by the staged entry on index match
   always_comb begin
      lk_e_valid  = tbl_valid[lk_idx];
      lk_e_tag    = tbl_tag[lk_idx];
      lk_e_target = tbl_target[lk_idx];
      lk_e_ctr    = tbl_ctr[lk_idx];
      if (stg_valid && (stg_idx == lk_idx)) begin
         lk_e_valid  = 1'b1;
         lk_e_tag    = stg_tag;
         lk_e_target = stg_target;
         lk_e_ctr    = stg_ctr;
      end
   end

   // Prediction: taken only on a tag hit with the counter in a taken state
   always_comb begin
      lk_hit         = lk_e_valid && (lk_e_tag == lk_tag);
      predict_result = lk_hit && lk_e_ctr[1];
      npc            = predict_result ? lk_e_target : (if_pc + 32'd4);
   end

   // Update read: same bypass as lookup so back-to-back updates chain
   always_comb begin
      up_e_valid  = tbl_valid[up_idx];
      up_e_tag    = tbl_tag[up_idx];
      up_e_target = tbl_target[up_idx];
      up_e_ctr    = tbl_ctr[up_idx];
      if (stg_valid && (stg_idx == up_idx)) begin
         up_e_valid  = 1'b1;
         up_e_tag    = stg_tag;
         up_e_target = stg_target;
         up_e_ctr    = stg_ctr;
      end
   end

   // New entry: saturating counter train on a hit, reallocation on a miss
   always_comb begin
      up_hit     = up_e_valid && (up_e_tag == up_tag);
      new_ctr    = up_e_ctr;
      new_target = up_e_target;
      if (up_hit) begin
         if (actual_result) begin
            if (up_e_ctr != 2'b11) new_ctr = up_e_ctr + 2'b01;
            new_target = branch_npc1;
         end else begin
            if (up_e_ctr != 2'b00) new_ctr = up_e_ctr - 2'b01;
         end
      end else begin
         new_ctr    = actual_result ? 2'b10 : 2'b01;
         new_target = actual_result ? branch_npc1 : 32'd0;
      end
   end

   // Staging register: load on capture, drain on commit
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         stg_valid  <= 1'b0;
         stg_idx    <= '0;
         stg_tag    <= '0;
         stg_target <= '0;
         stg_ctr    <= 2'b01;
      end else if (capture) begin
         stg_valid  <= 1'b1;
         stg_idx    <= up_idx;
         stg_tag    <= up_tag;
         stg_target <= new_target;
         stg_ctr    <= new_ctr;
      end else if (commit) begin
         stg_valid  <= 1'b0;
      end
   end

   // Table write-back of the staged entry
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i]  <= 1'b0;
            tbl_tag[i]    <= '0;
            tbl_target[i] <= '0;
            tbl_ctr[i]    <= 2'b01;
         end
      end else if (commit) begin
         tbl_valid[stg_idx]  <= 1'b1;
         tbl_tag[stg_idx]    <= stg_tag;
         tbl_target[stg_idx] <= stg_target;
         tbl_ctr[stg_idx]    <= stg_ctr;
      end
   end

`ifdef BP_STATS_EN
   logic [31:0] branches_q;
   logic [31:0] mispredicts_q;
   logic        unused_bits;

   // Statistics: count every capture and the flagged mispredictions, wrapping
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else if (capture) begin
         branches_q <= branches_q + 32'd1;
         if (predict_error) mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign stat_branches    = branches_q;
   assign stat_mispredicts = mispredicts_q;
   assign unused_bits      = ^{if_pc[1:0], branch_pc[1:0]};
`else
   logic unused_bits;

   assign stat_branches    = '0;
   assign stat_mispredicts = '0;
   assign unused_bits      = ^{if_pc[1:0], branch_pc[1:0], predict_error};
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor feeding next-PC guesses to the fetch stage and trained by resolution results from the execute stage. Combines a direct-mapped branch target buffer (tag, target, valid) with a 2-bit saturating counter per entry. Lookup is combinational from registered state. Updates pass through a one-entry staging register with read bypass, so a resolved branch affects the very next lookup.

## Interface

Parameters:
- `IDX_BITS`, 6: index width; the table has 2^IDX_BITS entries.

Ports:
- `clk_in` input 1: clock.
- `rst_n` input 1: **asynchronous, active-low reset.**
- `rdy_in` input 1: global ready; low freezes all state.
- `if_pc` input 32: fetch PC being predicted.
- `predict_result` output 1: predicted taken.
- `npc` output 32: predicted next PC.
- `predict_update` input 1: execute stage resolved a branch or jump this cycle.
- `predict_error` input 1: execute stage flagged a misprediction (statistics only).
- `actual_result` input 1: resolved taken.
- `branch_pc` input 32: PC of the resolved instruction.
- `branch_npc1` input 32: resolved next PC; this is the target when taken.
- `stat_branches` output 32: count of updates.
- `stat_mispredicts` output 32: count of updates with `predict_error`.

## Operation

- Index is `pc[IDX_BITS+1:2]`. Tag is `pc[31:IDX_BITS+2]`. `pc[1:0]` is ignored.
- Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Lookup (combinational):
  - Read the entry at the `if_pc` index.
  - If the staging register is valid and its index equals the lookup index, use the staged entry in place of the table entry (bypass).
  - `hit` = valid && tag matches.
  - `predict_result` = hit && `ctr[1]`.
  - `npc` = `predict_result` ? target : `if_pc + 4`, computed mod 2^32.
- Update capture, at a clock edge with `rdy_in` && `predict_update`:
  - Read the entry at the `branch_pc` index, through the same bypass.
  - On a hit:
    - `ctr` saturates: +1 capped at 3 if taken, -1 floored at 0 if not taken.
    - `target` is replaced by `branch_npc1` only if taken.
  - On a miss, the entry is reallocated:
    - valid=1, tag from `branch_pc`.
    - `ctr` = taken ? 2'b10 : 2'b01.
    - `target` = taken ? `branch_npc1` : 0.
  - The computed entry and its index are loaded into the staging register; staged valid is set to 1.
- Commit, at a clock edge with `rdy_in` and staged valid:
  - The staged entry is written to the table.
  - Staged valid clears, unless a new capture happens on the same edge; in that case the staging register holds the new update.
- Back-to-back updates to the same index: the second update reads the first update's result through the bypass, so counters chain correctly (01 → 10 → 11 over two taken updates).
- With `rdy_in` low: no capture, no commit, and no counter changes. Lookup outputs still follow `if_pc`.

## Timing

- Reset (async assert, deassert sampled on `clk_in`):
  - All valid bits are 0 and all `ctr` are 2'b01.
  - Staging register is invalid.
  - Stat counters are 0.
  - Therefore `predict_result`=0 and `npc`=`if_pc+4`.
- Reset asserted mid-operation discards any staged update immediately; the update is not written.
- Lookup latency: 0 cycles (same-cycle combinational path from `if_pc`).
- Update visibility:
  - An update sampled at edge N is visible to lookups in cycle N+1 (via bypass).
  - It is written into the table at edge N+1.
- Capture and commit on the same edge to different indices: both take effect.
- Capture and commit on the same edge to the same index: the new capture already includes the staged value, so no update is lost.

## Configuration

- `BP_STATS_EN` defined:
  - `stat_branches` increments on every capture.
  - `stat_mispredicts` increments on captures with `predict_error`=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- `BP_STATS_EN` undefined: both ports exist and are constant 0; no counter flops are synthesized.

## Test plan

- Reset, then `if_pc`=0x1000: expect `predict_result`=0 and `npc`=0x1004.
- One taken update: `branch_pc`=0x1000, `branch_npc1`=0x1200. Next cycle with `if_pc`=0x1000: expect taken (ctr=10) and `npc`=0x1200. With `if_pc`=0x1100 (same index when IDX_BITS=6, different tag): expect not taken and `npc`=0x1104.
- Consecutive-cycle updates on pc 0x2000: taken, taken, not-taken, not-taken, not-taken. Expected ctr sequence: 10, 11, 10, 01, 00. Expected `predict_result` after each update: 1, 1, 1, 0, 0.
- Hold `rdy_in`=0 while `predict_update`=1 for 3 cycles, then release: no state change and stat counters unchanged.
- With `BP_STATS_EN`: send 5 updates, 2 of them with `predict_error`=1. Expect `stat_branches`=5 and `stat_mispredicts`=2.
- Assert `rst_n` low in the same cycle a taken update is captured. After release, expect a lookup of that PC to predict not taken.
